pwconv_sched: RTL and testbench
===============================

// Module: pwconv_sched
// PURPOSE
//  Sequencer for the pointwise-conv MAC array. Walks the loop nest oc_grp -> pixel -> ic_grp.
//  Pops one activation word (MAC_IN_NUM ch) and one weight word per beat from the input/param FIFOs.
//  Marks the first/last ic beat of each accumulation and fires the output-FIFO write (MAC_OUT_NUM ch).
//  Sits between the layer config registers and the PW MAC datapath/FIFOs.
// PARAMETERS
//  CNT_WIDTH   10  width of pixel / group counters and cfg fields
//  MAC_LAT     3   cycles from a beat's read enables to its product being accumulated (>=1)
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          asynchronous, active-high reset
//  start          in   1          1-cycle pulse; latches cfg_*; ignored while busy
//  cfg_pix        in   CNT_WIDTH  pixels per layer
//  cfg_ic_grp     in   CNT_WIDTH  input-channel groups per pixel
//  cfg_oc_grp     in   CNT_WIDTH  output-channel groups
//  fifo_dempty    in   1          activation FIFO empty
//  fifo_pempty    in   1          weight FIFO empty
//  fifo_wfull     in   1          output FIFO full
//  fifo_rde       out  1          activation FIFO pop
//  fifo_rpe       out  1          weight FIFO pop (always == fifo_rde)
//  mac_clr        out  1          with pop: first ic beat, accumulator loads instead of adds
//  mac_last       out  1          with pop: last ic beat of this pixel/oc_grp
//  fifo_wde       out  1          output FIFO push (MAC result valid)
//  count          out  CNT_WIDTH  current pixel index
//  busy           out  1          layer in progress
//  done           out  1          1-cycle pulse at layer end
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters, in-flight flag and delay line cleared.
//   Reset mid-layer abandons the layer; no done pulse.
//  FSM states: IDLE, RUN, DRAIN, FIN.
//  IDLE: on start, latch cfg_*; zero counters.
//   If any cfg field == 0, go to FIN (no pops). Otherwise go to RUN; busy=1 from the next cycle.
//  RUN: issue a beat (fifo_rde=fifo_rpe=1) when all of these hold:
//   - !fifo_dempty && !fifo_pempty
//   - if the beat is the last ic beat: !fifo_wfull && no write in flight
//  Beat flags: mac_clr=(ic==0); mac_last=(ic==cfg_ic_grp-1).
//  Counters advance only on an issued beat. Order: ic, then pix, then oc.
//   Each wraps to 0 at cfg-1 and carries into the next.
//  count = pix.
//  Final beat (ic, pix, oc all at max): go to DRAIN.
//  In-flight flag: set when a mac_last beat issues; cleared when the matching fifo_wde fires.
//  fifo_wde: asserted exactly MAC_LAT cycles after each mac_last beat (shift-register delay line).
//   Exactly one push per (pix, oc_grp).
//  DRAIN: no pops; wait until the delay line is empty, then go to FIN.
//  FIN: done=1 for one cycle, busy=0; return to IDLE. start in FIN is ignored.
//  Pops are never issued while the corresponding FIFO is empty.
//   Empty/full may toggle every cycle; a stall leaves all counters unchanged.
//  cfg_ic_grp==1: every beat has mac_clr=mac_last=1.
//   Throughput is then 1 pixel per MAC_LAT+1 cycles because of the in-flight rule.
//  Total pops per layer = cfg_pix*cfg_ic_grp*cfg_oc_grp; total pushes = cfg_pix*cfg_oc_grp.
// TESTING
//  1. Basic run: cfg 4/3/2, FIFOs never empty or full.
//     -> 24 pops; 8 pushes, each MAC_LAT cycles after a mac_last beat.
//     -> mac_clr on pops 0,3,6..; one done pulse; busy low again after done.
//  2. cfg_ic_grp=1, pix=5, oc=1 -> 5 pops, all with mac_clr=mac_last=1.
//     -> pops spaced MAC_LAT+1 cycles apart; 5 pushes.
//  3. Backpressure: fifo_wfull held high 10 cycles while ic is at its last beat.
//     -> no pop during those cycles; counters frozen; resumes the cycle after wfull falls.
//  4. Input starvation: random dempty/pempty, 50% duty.
//     -> rde only when both not empty; pop sequence identical to scenario 1 (reference model compare).
//  5. Zero config: start with cfg_pix=0 -> no pops, no pushes; done 2 cycles after start.
//     -> start pulse while busy in scenario 1 is ignored (cfg unchanged).
//  6. Reset mid-layer at pop 10 -> all outputs 0 immediately; no done.
//     -> a fresh start runs a complete layer with correct counts.

Source files
------------

// File: rtl/pwconv_sched_if.sv
// pwconv_sched_if
//   Bundle of the control, configuration and FIFO handshake signals of the
//   pointwise-conv scheduler. clk/rst stay outside the bundle.
//   slave  : the scheduler itself (takes start/cfg/FIFO status, drives pops,
//            MAC beat flags, output push and layer status)
//   master : the environment (config registers, FIFOs, MAC datapath)
//   Signals:
//     start, cfg_pix, cfg_ic_grp, cfg_oc_grp        master -> slave
//     fifo_dempty, fifo_pempty, fifo_wfull          master -> slave
//     fifo_rde, fifo_rpe, mac_clr, mac_last,
//     fifo_wde, count, busy, done                   slave  -> master
interface pwconv_sched_if #(
  parameter int CNT_WIDTH = 10
);
  logic                 start;
  logic [CNT_WIDTH-1:0] cfg_pix;
  logic [CNT_WIDTH-1:0] cfg_ic_grp;
  logic [CNT_WIDTH-1:0] cfg_oc_grp;
  logic                 fifo_dempty;
  logic                 fifo_pempty;
  logic                 fifo_wfull;
  logic                 fifo_rde;
  logic                 fifo_rpe;
  logic                 mac_clr;
  logic                 mac_last;
  logic                 fifo_wde;
  logic [CNT_WIDTH-1:0] count;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, cfg_pix, cfg_ic_grp, cfg_oc_grp,
    input  fifo_dempty, fifo_pempty, fifo_wfull,
    output fifo_rde, fifo_rpe, mac_clr, mac_last, fifo_wde,
    output count, busy, done
  );

  modport master (
    output start, cfg_pix, cfg_ic_grp, cfg_oc_grp,
    output fifo_dempty, fifo_pempty, fifo_wfull,
    input  fifo_rde, fifo_rpe, mac_clr, mac_last, fifo_wde,
    input  count, busy, done
  );
endinterface

// File: rtl/pwconv_sched.sv
// pwconv_sched
//   Sequencer for the pointwise-conv MAC array. Walks the loop nest
//   oc_grp -> pixel -> ic_grp, popping one activation word and one weight
//   word per beat, flags the first/last input-channel beat of every
//   accumulation and pushes the MAC result MAC_LAT cycles after the last beat.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : pwconv_sched_if.slave (start/cfg in, FIFO status in,
//            pops / beat flags / push / count / busy / done out)
//   Parameters:
//     CNT_WIDTH : width of the pixel/group counters and cfg fields
//     MAC_LAT   : read-enable to accumulate latency of the MAC (>= 1)
module pwconv_sched #(
  parameter int CNT_WIDTH = 10,
  parameter int MAC_LAT   = 3
) (
  input logic           clk,
  input logic           rst,
  pwconv_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MAC_LAT-1:0]   DL_ZERO  = {MAC_LAT{1'b0}};

  state_t               state;
  state_t               state_nx;
  logic [CNT_WIDTH-1:0] cfg_pix_q;
  logic [CNT_WIDTH-1:0] cfg_ic_q;
  logic [CNT_WIDTH-1:0] cfg_oc_q;
  logic [CNT_WIDTH-1:0] ic;
  logic [CNT_WIDTH-1:0] pix;
  logic [CNT_WIDTH-1:0] oc;
  logic                 in_flight;
  logic [MAC_LAT-1:0]   dline;
  logic [MAC_LAT-1:0]   dline_nx;
  logic                 busy_q;
  logic                 done_q;

  logic ic_max;
  logic pix_max;
  logic oc_max;
  logic beat;
  logic last_beat;
  logic cfg_zero;

  // Beat qualification: both read FIFOs non-empty; a closing beat also needs
  // room in the output FIFO and no result still travelling through the MAC,
  // so at most one output push is ever pending.
  always_comb begin
    ic_max    = (ic  == (cfg_ic_q  - CNT_ONE));
    pix_max   = (pix == (cfg_pix_q - CNT_ONE));
    oc_max    = (oc  == (cfg_oc_q  - CNT_ONE));
    cfg_zero  = (bus.cfg_pix == CNT_ZERO) || (bus.cfg_ic_grp == CNT_ZERO) ||
                (bus.cfg_oc_grp == CNT_ZERO);
    beat      = 1'b0;
    if (state == S_RUN) begin
      beat = !bus.fifo_dempty && !bus.fifo_pempty &&
             (!ic_max || (!bus.fifo_wfull && !in_flight));
    end else begin
      beat = 1'b0;
    end
    last_beat = beat && ic_max;
    // Shift the closing-beat marker one stage per cycle; the top stage is the push.
    dline_nx    = dline << 1'b1;
    dline_nx[0] = last_beat;
  end

  // Next-state logic of the layer sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = cfg_zero ? S_FIN : S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_beat && pix_max && oc_max) begin
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_DRAIN: begin
        if (dline == DL_ZERO) begin
          state_nx = S_FIN;
        end else begin
          state_nx = S_DRAIN;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register plus registered busy/done status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      done_q <= (state == S_FIN);
    end
  end

  // Config latch on start and the ic -> pix -> oc counter nest; a stall holds all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_pix_q <= CNT_ZERO;
      cfg_ic_q  <= CNT_ZERO;
      cfg_oc_q  <= CNT_ZERO;
      ic        <= CNT_ZERO;
      pix       <= CNT_ZERO;
      oc        <= CNT_ZERO;
    end else if ((state == S_IDLE) && bus.start) begin
      cfg_pix_q <= bus.cfg_pix;
      cfg_ic_q  <= bus.cfg_ic_grp;
      cfg_oc_q  <= bus.cfg_oc_grp;
      ic        <= CNT_ZERO;
      pix       <= CNT_ZERO;
      oc        <= CNT_ZERO;
    end else if (beat) begin
      if (ic_max) begin
        ic <= CNT_ZERO;
        if (pix_max) begin
          pix <= CNT_ZERO;
          oc  <= oc_max ? CNT_ZERO : (oc + CNT_ONE);
        end else begin
          pix <= pix + CNT_ONE;
        end
      end else begin
        ic <= ic + CNT_ONE;
      end
    end
  end

  // Result delay line and the in-flight flag that spans it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dline     <= DL_ZERO;
      in_flight <= 1'b0;
    end else begin
      dline <= dline_nx;
      if (last_beat) begin
        in_flight <= 1'b1;
      end else if (dline[MAC_LAT-1]) begin
        in_flight <= 1'b0;
      end
    end
  end

  // Pops and beat flags must react to this cycle's FIFO status, so they are
  // decoded from registered state and the live empty/full inputs.
  assign bus.fifo_rde = beat;
  assign bus.fifo_rpe = beat;
  assign bus.mac_clr  = beat && (ic == CNT_ZERO);
  assign bus.mac_last = last_beat;
  assign bus.fifo_wde = dline[MAC_LAT-1];
  assign bus.count    = pix;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pwconv_sched.sv
// tb_pwconv_sched
//   Self-checking bench for pwconv_sched. A table of layer configurations is
//   run against a reference model that lists the expected beats from the
//   loop nest and times every push from the closing beat that caused it.
//   Hand-written sequences cover backpressure, zero config and mid-layer reset.
module tb_pwconv_sched;
  localparam int CW      = 10;
  localparam int MAC_LAT = 3;
  localparam int BUDGET  = 3000;

  logic clk;
  logic rst;

  pwconv_sched_if #(.CNT_WIDTH(CW)) bus ();

  pwconv_sched #(.CNT_WIDTH(CW), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit clr;
    bit last;
    int pix;
  } beat_t;

  typedef struct {
    int pix;
    int icg;
    int ocg;
    int mode;       // 0 ready, 1 random FIFO status, 2 wfull window cycles 1..12
    int spur;       // cycle of an extra start pulse (-1 none)
    int exp_pops;
    int exp_pushes;
  } vec_t;

  int n_total;
  int n_pass;
  int pop_cyc[$];
  int pop_cnt;
  int push_cnt;
  int done_cyc;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  task automatic run_layer(input int p, input int icg, input int ocg,
                           input int mode, input int spur);
    beat_t exp_q[$];
    int    due_q[$];
    beat_t e;
    bit    finished;
    bit    due;
    for (int o = 0; o < ocg; o++)
      for (int x = 0; x < p; x++)
        for (int i = 0; i < icg; i++)
          exp_q.push_back('{clr: (i == 0), last: (i == icg - 1), pix: x});
    pop_cyc.delete();
    pop_cnt  = 0;
    push_cnt = 0;
    done_cyc = -1;
    finished = 1'b0;

    @(negedge clk);
    bus.start       = 1'b1;
    bus.cfg_pix     = CW'(p);
    bus.cfg_ic_grp  = CW'(icg);
    bus.cfg_oc_grp  = CW'(ocg);
    bus.fifo_dempty = 1'b0;
    bus.fifo_pempty = 1'b0;
    bus.fifo_wfull  = 1'b0;

    for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == spur);
      if (cyc == spur) begin
        bus.cfg_pix    = CW'(7);
        bus.cfg_ic_grp = CW'(7);
        bus.cfg_oc_grp = CW'(7);
      end
      case (mode)
        1: begin
          bus.fifo_dempty = 1'($urandom_range(0, 1));
          bus.fifo_pempty = 1'($urandom_range(0, 1));
          bus.fifo_wfull  = ($urandom_range(0, 3) == 0);
        end
        2: begin
          bus.fifo_dempty = 1'b0;
          bus.fifo_pempty = 1'b0;
          bus.fifo_wfull  = (cyc <= 12);
        end
        default: begin
          bus.fifo_dempty = 1'b0;
          bus.fifo_pempty = 1'b0;
          bus.fifo_wfull  = 1'b0;
        end
      endcase
      #1;
      if (cyc == 1) check("busy_after_start", bus.busy, (p * icg * ocg) != 0);
      if (mode == 2 && cyc >= 3 && cyc <= 12)
        check("bp_frozen", {bus.fifo_rde, bus.count}, 0);
      if (bus.fifo_rde) begin
        check("rpe_eq_rde", bus.fifo_rpe, 1);
        check("pop_when_empty", {bus.fifo_dempty, bus.fifo_pempty}, 0);
        if (exp_q.size() == 0) begin
          check("extra_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_seq", {bus.mac_clr, bus.mac_last, bus.count},
                {e.clr, e.last, e.pix[CW-1:0]});
        end
        if (bus.mac_last) begin
          check("last_pop_wfull", bus.fifo_wfull, 0);
          check("last_pop_inflight", due_q.size(), 0);
          due_q.push_back(cyc + MAC_LAT);
        end
        pop_cyc.push_back(cyc);
        pop_cnt++;
      end else begin
        check("flags_without_pop", {bus.fifo_rpe, bus.mac_clr, bus.mac_last}, 0);
      end
      due = (due_q.size() > 0) && (due_q[0] == cyc);
      if (bus.fifo_wde || due) begin
        check("push_timing", bus.fifo_wde, due);
        if (due) void'(due_q.pop_front());
        if (bus.fifo_wde) push_cnt++;
      end
      if (bus.done) begin
        finished = 1'b1;
        done_cyc = cyc;
      end
    end
    bus.start = 1'b0;
    check("done_seen", finished, 1);
    check("beats_left", exp_q.size(), 0);
    check("push_outstanding", due_q.size(), 0);
    check("busy_at_done", bus.busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("idle_after_done", {bus.busy, bus.done, bus.fifo_rde, bus.fifo_wde}, 0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    n_total = 0;
    n_pass  = 0;
    vecs[0] = '{pix: 4, icg: 3, ocg: 2, mode: 0, spur: 5,  exp_pops: 24, exp_pushes: 8};
    vecs[1] = '{pix: 5, icg: 1, ocg: 1, mode: 0, spur: -1, exp_pops: 5,  exp_pushes: 5};
    vecs[2] = '{pix: 4, icg: 3, ocg: 2, mode: 1, spur: -1, exp_pops: 24, exp_pushes: 8};
    vecs[3] = '{pix: 0, icg: 3, ocg: 2, mode: 0, spur: 1,  exp_pops: 0,  exp_pushes: 0};
    vecs[4] = '{pix: 3, icg: 2, ocg: 0, mode: 0, spur: -1, exp_pops: 0,  exp_pushes: 0};
    vecs[5] = '{pix: 2, icg: 3, ocg: 1, mode: 2, spur: -1, exp_pops: 6,  exp_pushes: 2};
    vecs[6] = '{pix: 1, icg: 1, ocg: 1, mode: 0, spur: -1, exp_pops: 1,  exp_pushes: 1};

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.cfg_pix     = '0;
    bus.cfg_ic_grp  = '0;
    bus.cfg_oc_grp  = '0;
    bus.fifo_dempty = 1'b1;
    bus.fifo_pempty = 1'b1;
    bus.fifo_wfull  = 1'b0;
    #2;
    check("reset_state", {bus.fifo_rde, bus.fifo_rpe, bus.mac_clr, bus.mac_last,
                          bus.fifo_wde, bus.count, bus.busy, bus.done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_layer(vecs[v].pix, vecs[v].icg, vecs[v].ocg, vecs[v].mode, vecs[v].spur);
      check("pops_total", pop_cnt, vecs[v].exp_pops);
      check("pushes_total", push_cnt, vecs[v].exp_pushes);
      if (vecs[v].exp_pops == 0) check("zero_cfg_done_cycle", done_cyc, 2);
      if (vecs[v].mode == 2) begin
        if (pop_cyc.size() >= 3) begin
          check("bp_pop_before_stall", pop_cyc[1], 2);
          check("bp_resume_cycle", pop_cyc[2], 13);
        end else begin
          check("bp_pop_count", pop_cyc.size(), 3);
        end
      end
      if (vecs[v].icg == 1 && vecs[v].mode == 0) begin
        for (int k = 1; k < pop_cyc.size(); k++)
          check("ic1_pop_spacing", pop_cyc[k] - pop_cyc[k-1], MAC_LAT + 1);
      end
    end

    // Randomized layers under random FIFO status.
    for (int r = 0; r < 6; r++) begin
      int p;
      int i;
      int o;
      p = $urandom_range(1, 5);
      i = $urandom_range(1, 4);
      o = $urandom_range(1, 3);
      run_layer(p, i, o, 1, -1);
      check("rand_pops", pop_cnt, p * i * o);
      check("rand_pushes", push_cnt, p * o);
    end

    // Reset in the middle of a layer, then a fresh complete layer.
    begin
      int seen;
      bit hit;
      seen = 0;
      hit  = 1'b0;
      @(negedge clk);
      bus.start       = 1'b1;
      bus.cfg_pix     = CW'(4);
      bus.cfg_ic_grp  = CW'(3);
      bus.cfg_oc_grp  = CW'(2);
      bus.fifo_dempty = 1'b0;
      bus.fifo_pempty = 1'b0;
      bus.fifo_wfull  = 1'b0;
      for (int c = 1; c <= 200 && !hit; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        if (bus.fifo_rde) seen++;
        if (seen == 11) hit = 1'b1;
      end
      check("reset_reached_pop10", hit, 1);
      #1;
      rst = 1'b1;
      #1;
      check("reset_mid_outputs", {bus.fifo_rde, bus.fifo_rpe, bus.mac_clr, bus.mac_last,
                                  bus.fifo_wde, bus.count, bus.busy, bus.done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1;
        check("no_done_after_reset", {bus.done, bus.busy}, 0);
      end
      run_layer(4, 3, 2, 0, -1);
      check("post_reset_pops", pop_cnt, 24);
      check("post_reset_pushes", push_cnt, 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
